// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction fetch slice.
// Holds the PC width, the default halt word and the fetch FSM encoding.
// No logic here beyond a saturating counter helper.
package mips_pkg;

  localparam int PC_W = 8;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_000C;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mips_pc_reg.sv
// Program counter register with load, increment (modulo 2^PC_W) and hold.
// Latency: new value visible one clk after load_en/inc_en.
// Backpressure: none; the caller decides when to hold by deasserting both enables.
module mips_pc_reg
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_pc,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next PC: load has priority over increment; the add wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_pc;
    end else if (inc_en) begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= START_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/mips_instr_fetch.sv
// Instruction fetch stage: drives memory address, registers the returned word for decode.
// Latency: 1 cycle from program_counter to instr_valid.
// Backpressure: valid/ready; output and PC hold while decode_ready=0, redirect flushes.
module mips_instr_fetch
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC  = 8'h00,
  parameter logic [31:0]     HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] program_counter,
  input  logic [31:0]     instruction,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            decode_ready,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted,
  output logic [15:0]     instr_count
);

  fetch_state_e    state_q, state_d;
  logic [31:0]     instr_out_q, instr_out_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [15:0]     instr_count_q, instr_count_d;

  logic            pc_load;
  logic            pc_inc;
  logic            accept;

  assign accept = instr_valid_q && decode_ready;

  mips_pc_reg #(
    .START_PC (START_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (pc_load),
    .load_pc (redirect_pc),
    .inc_en  (pc_inc),
    .pc      (program_counter)
  );

  // Next-state and datapath control. An accepted word is always counted,
  // even when a redirect flushes the slot behind it; halt only takes effect
  // when no redirect arrives on the same edge.
  always_comb begin
    state_d       = state_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    instr_count_d = instr_count_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;

    case (state_q)
      ST_RUN, ST_STALL: begin
        if (accept) begin
          instr_count_d = sat_inc16(instr_count_q);
        end
        if (redirect_en) begin
          pc_load       = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = ST_RUN;
        end else if (accept && (instr_out_q == HALT_WORD)) begin
          instr_valid_d = 1'b0;
          state_d       = ST_HALTED;
        end else if (!instr_valid_q || decode_ready) begin
          instr_out_d   = instruction;
          instr_pc_d    = program_counter;
          instr_valid_d = 1'b1;
          pc_inc        = 1'b1;
          state_d       = ST_RUN;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_HALTED: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      instr_out_q   <= 32'h0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_count_q <= 16'h0;
    end else begin
      state_q       <= state_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr_count = instr_count_q;
  assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_mips_instr_fetch.sv
// Directed bench for mips_instr_fetch: sequential fetch, stall, redirect, halt, reset.
// A second instance with START_PC=8'hFE covers PC wrap.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
module tb_mips_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [7:0]  program_counter, program_counter2;
  logic [31:0] instruction, instruction2;
  logic [31:0] instr_out, instr_out2;
  logic [7:0]  instr_pc, instr_pc2;
  logic        instr_valid, instr_valid2;
  logic        decode_ready;
  logic        redirect_en;
  logic [7:0]  redirect_pc;
  logic        halted, halted2;
  logic [15:0] instr_count, instr_count2;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  assign instruction  = mem[program_counter];
  assign instruction2 = mem[program_counter2];

  mips_instr_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .program_counter (program_counter),
    .instruction     (instruction),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .decode_ready    (decode_ready),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .halted          (halted),
    .instr_count     (instr_count)
  );

  mips_instr_fetch #(.START_PC(8'hFE)) dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .program_counter (program_counter2),
    .instruction     (instruction2),
    .instr_out       (instr_out2),
    .instr_pc        (instr_pc2),
    .instr_valid     (instr_valid2),
    .decode_ready    (1'b1),
    .redirect_en     (1'b0),
    .redirect_pc     (8'h00),
    .halted          (halted2),
    .instr_count     (instr_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;
    rst_n        = 1'b0;
    decode_ready = 1'b1;
    redirect_en  = 1'b0;
    redirect_pc  = 8'h00;
    step();
    step();

    // Reset state
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_count", {16'b0, instr_count}, 32'd0);
    chk("rst_pc", {24'b0, program_counter}, 32'h00);
    chk("rst_iout", instr_out, 32'h0);
    chk("rst_ipc", {24'b0, instr_pc}, 32'h00);
    chk("rst_pc_wrap", {24'b0, program_counter2}, 32'hFE);

    // Streaming fetch, ready held high; wrap instance runs alongside
    rst_n = 1'b1;
    step();
    chk("seq_valid0", {31'b0, instr_valid}, 32'd1);
    chk("seq_ipc0", {24'b0, instr_pc}, 32'h00);
    chk("seq_iout0", instr_out, 32'h1000_0000);
    chk("wrap_ipc0", {24'b0, instr_pc2}, 32'hFE);
    chk("wrap_valid0", {31'b0, instr_valid2}, 32'd1);
    step();
    chk("seq_ipc1", {24'b0, instr_pc}, 32'h01);
    chk("seq_cnt1", {16'b0, instr_count}, 32'd1);
    chk("wrap_ipc1", {24'b0, instr_pc2}, 32'hFF);
    step();
    chk("seq_ipc2", {24'b0, instr_pc}, 32'h02);
    chk("wrap_ipc2", {24'b0, instr_pc2}, 32'h00);
    step();
    chk("seq_ipc3", {24'b0, instr_pc}, 32'h03);
    chk("wrap_ipc3", {24'b0, instr_pc2}, 32'h01);
    step();
    chk("seq_ipc4", {24'b0, instr_pc}, 32'h04);
    chk("seq_cnt4", {16'b0, instr_count}, 32'd4);

    // Stall for 3 cycles with instr_pc=04
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ipc", {24'b0, instr_pc}, 32'h04);
      chk("stall_iout", instr_out, 32'h1000_0004);
      chk("stall_pc", {24'b0, program_counter}, 32'h05);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_cnt", {16'b0, instr_count}, 32'd4);
    end
    decode_ready = 1'b1;
    step();
    chk("rel_ipc", {24'b0, instr_pc}, 32'h05);
    chk("rel_cnt", {16'b0, instr_count}, 32'd5);

    // Redirect while stalled: held word dropped, not counted
    decode_ready = 1'b0;
    redirect_en  = 1'b1;
    redirect_pc  = 8'h40;
    step();
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_pc", {24'b0, program_counter}, 32'h40);
    chk("redir_cnt", {16'b0, instr_count}, 32'd5);
    redirect_en  = 1'b0;
    decode_ready = 1'b1;
    step();
    chk("redir_ipc", {24'b0, instr_pc}, 32'h40);
    chk("redir_iout", instr_out, 32'h1000_0040);
    chk("redir_cnt2", {16'b0, instr_count}, 32'd5);
    step();
    chk("redir_ipc2", {24'b0, instr_pc}, 32'h41);
    chk("redir_cnt3", {16'b0, instr_count}, 32'd6);

    // Redirect coinciding with acceptance: accepted word counted
    redirect_en = 1'b1;
    redirect_pc = 8'h80;
    step();
    chk("racc_cnt", {16'b0, instr_count}, 32'd7);
    chk("racc_valid", {31'b0, instr_valid}, 32'd0);
    chk("racc_pc", {24'b0, program_counter}, 32'h80);
    redirect_en = 1'b0;
    step();
    chk("racc_ipc", {24'b0, instr_pc}, 32'h80);
    chk("racc_cnt2", {16'b0, instr_count}, 32'd7);

    // Halt word at address 3
    mem[3] = 32'h0000_000C;
    rst_n  = 1'b0;
    step();
    chk("rst2_cnt", {16'b0, instr_count}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_seq_ipc", {24'b0, instr_pc}, i);
    end
    chk("halt_iout", instr_out, 32'h0000_000C);
    step();
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_cnt", {16'b0, instr_count}, 32'd4);
    chk("halt_pc", {24'b0, program_counter}, 32'h04);
    redirect_en = 1'b1;
    redirect_pc = 8'h20;
    step();
    step();
    chk("halt_redir_pc", {24'b0, program_counter}, 32'h04);
    chk("halt_redir_halted", {31'b0, halted}, 32'd1);
    chk("halt_redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_redir_cnt", {16'b0, instr_count}, 32'd4);
    redirect_en = 1'b0;

    // One-cycle reset while halted
    rst_n = 1'b0;
    step();
    chk("hrst_halted", {31'b0, halted}, 32'd0);
    chk("hrst_cnt", {16'b0, instr_count}, 32'd0);
    chk("hrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("hrst_pc", {24'b0, program_counter}, 32'h00);
    rst_n = 1'b1;
    step();
    chk("hrst_ipc", {24'b0, instr_pc}, 32'h00);
    chk("hrst_valid2", {31'b0, instr_valid}, 32'd1);
    chk("hrst_iout", instr_out, 32'h1000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
